// File: rtl/priority_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way priority arbiter.
package arb_pkg;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDW-1:0] idx);
    logic [ARB_N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/priority_arbiter_prio_enc8.sv
// Highest-set-bit encoder; idx is 0 when no bit is set.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = 3'd0;
    // Ascending scan so the last (highest) set bit wins.
    for (int i = 0; i < 8; i++) begin
      if (in[i]) idx = 3'(i);
    end
    any = |in;
  end

endmodule

// File: rtl/priority_arbiter.sv
// 8-way fixed-priority arbiter with registered one-hot grant and per-owner hold timeout.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = ARB_IDW,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam logic              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              owner_req, rel, expire, rearb;
  logic [N-1:0]      mask, req_masked;
  logic [2:0]        win_idx;
  logic              win_any;

  // Arbitration-point detection; kept apart from next-state logic so the
  // mask -> encoder -> next-state path stays acyclic.
  always_comb begin
    owner_req  = req[gnt_id_q];
    rel        = (state_q == ST_GRANT) && !owner_req;
    expire     = (state_q == ST_GRANT) && owner_req && HOLD_EN && (hold_q == HOLD_LAST);
    rearb      = (state_q == ST_IDLE) || rel || expire;
    mask       = expire ? onehot8(gnt_id_q) : '0;
    req_masked = req & ~mask;
  end

  prio_enc8 u_enc (
    .in  (req_masked),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (rearb) begin
      // A release has priority over expiry, so timeout only fires when the owner still requests.
      timeout_d = expire;
      hold_d    = '0;
      if (win_any) begin
        state_d  = ST_GRANT;
        gnt_d    = onehot8(win_idx);
        gnt_id_d = win_idx;
      end else begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    end else if (hold_q != HOLD_SAT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: directed vector table on a MAX_HOLD=4 instance plus
// randomized traffic on MAX_HOLD=4 and MAX_HOLD=1 instances against an ownership model.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt4, gnt1;
  logic [2:0] id4, id1;
  logic       vld4, vld1, to4, to1;

  always #5 clk = ~clk;

  priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt4), .gnt_id(id4), .gnt_valid(vld4), .timeout(to4)
  );

  priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(vld1), .timeout(to1)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  // Reference model: who owns the resource and for how many cycles so far.
  int   m_own[2];
  int   m_cnt[2];
  logic m_to[2];
  int   m_max[2] = '{4, 1};

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic r, input logic [7:0] q);
    logic [7:0] others;
    m_to[k] = 1'b0;
    if (r) begin
      m_own[k] = -1;
      m_cnt[k] = 0;
    end else if (m_own[k] < 0 || !q[m_own[k]]) begin
      m_own[k] = highest(q);
      m_cnt[k] = 1;
    end else if (m_max[k] != 0 && m_cnt[k] == m_max[k]) begin
      m_to[k]  = 1'b1;
      others   = q;
      others[m_own[k]] = 1'b0;
      m_own[k] = highest(others);
      m_cnt[k] = 1;
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int k, input logic [7:0] g, input logic [2:0] id,
                             input logic v, input logic t);
    logic [7:0] eg;
    logic [2:0] eid;
    eg  = (m_own[k] >= 0) ? (8'h01 << m_own[k]) : 8'h00;
    eid = (m_own[k] >= 0) ? 3'(m_own[k]) : 3'd0;
    check((k == 0) ? "mdl4_gnt" : "mdl1_gnt", g, eg);
    check((k == 0) ? "mdl4_id"  : "mdl1_id",  {5'd0, id}, {5'd0, eid});
    check((k == 0) ? "mdl4_vld" : "mdl1_vld", {7'd0, v}, {7'd0, (m_own[k] >= 0)});
    check((k == 0) ? "mdl4_to"  : "mdl1_to",  {7'd0, t}, {7'd0, m_to[k]});
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(0, r, q);
    model_step(1, r, q);
    #1;
    check_model(0, gnt4, id4, vld4, to4);
    check_model(1, gnt1, id1, vld1, to1);
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                     input logic [2:0] id, input logic t, input int rep);
    for (int i = 0; i < rep; i++) tbl.push_back('{r, q, g, id, t});
  endtask

  initial begin
    logic [7:0] cur;
    rst = 1'b1;
    req = 8'h00;
    m_own = '{-1, -1};
    m_cnt = '{0, 0};
    m_to  = '{1'b0, 1'b0};

    // Directed rows for the MAX_HOLD=4 instance: inputs before an edge, outputs after it.
    add(1, 8'h00, 8'h00, 3'd0, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 5);
    add(0, 8'h25, 8'h20, 3'd5, 0, 3);
    add(0, 8'h05, 8'h04, 3'd2, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);
    add(0, 8'h81, 8'h80, 3'd7, 0, 4);
    add(0, 8'h81, 8'h01, 3'd0, 1, 1);
    add(0, 8'h81, 8'h01, 3'd0, 0, 3);
    add(0, 8'h81, 8'h80, 3'd7, 1, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);
    add(0, 8'h08, 8'h08, 3'd3, 0, 4);
    add(0, 8'h08, 8'h00, 3'd0, 1, 1);
    add(0, 8'h08, 8'h08, 3'd3, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);
    add(0, 8'h04, 8'h04, 3'd2, 0, 1);
    add(0, 8'h44, 8'h04, 3'd2, 0, 2);
    add(0, 8'h40, 8'h40, 3'd6, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);
    add(0, 8'h10, 8'h10, 3'd4, 0, 2);
    add(1, 8'h10, 8'h00, 3'd0, 0, 1);
    add(0, 8'h10, 8'h10, 3'd4, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);
    // Owner drops on the very cycle its budget would expire: plain release, no pulse.
    add(0, 8'h02, 8'h02, 3'd1, 0, 4);
    add(0, 8'h01, 8'h01, 3'd0, 0, 1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req);
      check("tbl_gnt", gnt4, tbl[i].gnt);
      check("tbl_id", {5'd0, id4}, {5'd0, tbl[i].id});
      check("tbl_vld", {7'd0, vld4}, {7'd0, (tbl[i].gnt != 8'h00)});
      check("tbl_to", {7'd0, to4}, {7'd0, tbl[i].to});
    end

    // MAX_HOLD=1 with two requesters alternates between them every cycle.
    step(0, 8'h00);
    step(0, 8'h30);
    check("rr1_a", gnt1, 8'h20);
    step(0, 8'h30);
    check("rr1_b", gnt1, 8'h10);
    check("rr1_to", {7'd0, to1}, 8'h01);
    step(0, 8'h30);
    check("rr1_c", gnt1, 8'h20);

    // Random traffic: slowly drifting request vector with occasional bursts and resets.
    cur = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) cur = 8'($urandom);
      step(($urandom_range(0, 99) == 0), cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Sequential 8-way arbiter that shares a single downstream resource among eight requesters. Each arbitration picks the highest-index active request, which matches the team's priority-encoder convention. The winner holds a registered one-hot grant until it drops its request or its hold budget runs out, and the owner is then rotated out. The block sits between request sources and the shared datapath, and drives the datapath's select lines from `gnt_id`.

## Interface
- `N`, 8: number of requesters; fixed at 8 for this revision.
- `IDW`, 3: width of the grant index, equal to clog2(N).
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner. Legal range 1..255; 0 disables the timeout.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req` input N: request vector; bit i high means requester i wants the resource.
- `gnt` output N: one-hot grant; all zero when no owner.
- `gnt_id` output IDW: binary index of the current owner; 0 when `gnt_valid` is low.
- `gnt_valid` output 1: high while any grant is asserted (OR of `gnt`).
- `timeout` output 1: one-cycle pulse when an owner is forcibly released.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner registered, hold counter running.
- Arbitration function: the winner is the highest set bit of (`req` AND NOT `mask`). A request vector of zero means no winner.
- IDLE:
  - If a winner exists, load `gnt`/`gnt_id`, clear the hold counter, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, owner's `req` bit low (release):
  - Re-arbitrate in the same cycle among the remaining requests.
  - If a winner exists, stay in GRANT with the new owner. There is no bubble cycle.
  - Otherwise go to IDLE.
- GRANT, owner's `req` high and hold counter == MAX_HOLD-1 (timeout, only when MAX_HOLD≠0):
  - Pulse `timeout`.
  - Re-arbitrate with `mask` = one-hot of the current owner, for this arbitration only.
  - If no other requester exists, go to IDLE. The previous owner may win the next arbitration normally.
- GRANT, otherwise: hold the grant and increment the hold counter (8-bit, saturating, never wraps).
- Higher-priority requests arriving mid-grant do not preempt. They win at the next arbitration point.
- `mask` is zero except in the timeout case.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, state IDLE, hold counter 0.
- Latency: `req` sampled at edge t produces `gnt` visible after edge t (cycle t+1). Fully registered outputs; no combinational path from `req` to `gnt`.
- Grant duration under timeout is exactly MAX_HOLD cycles.
- MAX_HOLD=1: every grant lasts one cycle. With two or more requesters this round-robins between the top two.
- Release and timeout in the same cycle: release wins and `timeout` stays low.
- `rst` asserted mid-grant: all outputs are 0 in the following cycle; no `timeout` pulse.
- `timeout` coincides with the cycle in which the new `gnt` (or zero) appears.

## Structure
- Shared package `arb_pkg`:
  - constants `ARB_N`=8 and `ARB_IDW`=3;
  - state enum {ST_IDLE, ST_GRANT};
  - hold-counter width constant (8).
- One combinational sub-module `prio_enc8`:
  - input `in[7:0]`; outputs `idx[2:0]` and `any`;
  - returns the highest set bit.
  - Instantiated once on the masked request vector.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles -> `gnt`=0, `gnt_valid`=0, `timeout`=0 throughout.
- `req`=8'b0010_0101 at cycle 0 -> cycle 1 `gnt`=8'h20, `gnt_id`=5. Drop bit 5 at cycle 3 -> cycle 4 `gnt`=8'h04, `gnt_id`=2, with no zero cycle between.
- MAX_HOLD=4, `req` held at 8'h81 -> `gnt_id`=7 for cycles 1–4. Cycle 5 `gnt_id`=0 and `timeout`=1. Cycle 9 `gnt_id`=7 with another `timeout` pulse.
- MAX_HOLD=4, only `req[3]` held -> `gnt`=8'h08 for 4 cycles. Then one cycle of `gnt`=0 with `timeout`=1, then `gnt`=8'h08 again.
- Owner 2 granted; `req[6]` rises mid-grant -> `gnt` stays 8'h04 until `req[2]` drops, then `gnt`=8'h40 the next cycle.
- `rst` pulsed while `gnt`=8'h10 -> next cycle all outputs are 0. After reset releases with `req[4]` still high, `gnt`=8'h10 reappears one cycle later.
